// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time writer for the S-Machine instruction store.
// Framed byte stream in, big-endian 16-bit words out, CPU held until checksum.
module inst_mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // LEN = 0 means a full store, but LEN stays an 8-bit field.
    localparam int FULL_CNT = (ADDR_W >= 8) ? 256 : (1 << ADDR_W);
    localparam logic [8:0] FULL_CNT_V = 9'(FULL_CNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;

    assign rx_ready  = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = rx_valid && rx_ready;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;

    // Register bank, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Frame parser: next state, write strobe and completion flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    cnt_d   = (rx_data == 8'd0) ? FULL_CNT_V
                                                : {1'b0, rx_data};
                    acc_d   = rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    wdata_d = {hi_q, rx_data};
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = cnt_q - 9'd1;
                    acc_d   = acc_q ^ rx_data;
                    state_d = (cnt_q == 9'd1) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    done_d  = 1'b1;
                    err_d   = (rx_data != acc_q);
                    hold_d  = (rx_data != acc_q);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
